// File: rtl/tri_itag_alloc.sv
// In-order age-tag allocator: hands out sequential tags (wrap bit in the MSB),
// retires them oldest first and rewinds the next-tag pointer on flush.
module tri_itag_alloc #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc_req,
  output logic            alloc_gnt,
  output logic [SIZE-1:0] alloc_itag,
  input  logic            retire_val,
  input  logic [SIZE-1:0] retire_itag,
  input  logic            flush_val,
  input  logic [SIZE-1:0] flush_itag,
  output logic [SIZE-1:0] oldest_itag,
  output logic [SIZE-1:0] count,
  output logic            empty,
  output logic            full,
  output logic            err
);

  localparam logic [SIZE-1:0] ONE     = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE-1:0] MAX_CNT = {1'b1, {(SIZE-1){1'b0}}};

  logic [SIZE-1:0] r_nxt;
  logic [SIZE-1:0] r_old;
  logic            r_err;

  logic [SIZE-1:0] w_count;
  logic            w_empty;
  logic            w_full;
  logic            w_gnt;
  logic            w_ret_ok;
  logic            w_ret_bad;
  logic [SIZE-1:0] w_flush_off;
  logic            w_flush_ok;
  logic            w_flush_bad;
  logic [SIZE-1:0] w_nxt_d;
  logic [SIZE-1:0] w_old_d;
  logic            w_err_d;

  // Occupancy never exceeds half the tag space, so the modular difference is exact.
  assign w_count = r_nxt - r_old;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == MAX_CNT);

  // Handshake: a tag is consumed only in a cycle where alloc_req and alloc_gnt
  // are both high; alloc_itag is the granted tag in that same cycle.
  assign w_gnt = alloc_req & ~w_full & ~flush_val & rst_n;

  assign w_ret_ok  = retire_val & ~w_empty & (retire_itag == r_old);
  assign w_ret_bad = retire_val & ~w_ret_ok;

  // A flush may land anywhere from the oldest tag up to the next tag (no-op).
  assign w_flush_off = flush_itag - r_old;
  assign w_flush_ok  = flush_val & (w_flush_off <= w_count);
  assign w_flush_bad = flush_val & ~w_flush_ok;

  always_comb begin
    w_nxt_d = r_nxt;
    w_old_d = r_old;
    w_err_d = r_err | w_ret_bad | w_flush_bad;
    if (w_ret_ok) begin
      w_old_d = r_old + ONE;
    end
    if (w_flush_ok) begin
      // Flushing the tag that retires this cycle keeps it committed.
      if (w_ret_ok && (flush_itag == r_old)) begin
        w_nxt_d = r_old + ONE;
      end else begin
        w_nxt_d = flush_itag;
      end
    end else if (w_gnt) begin
      w_nxt_d = r_nxt + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nxt <= '0;
      r_old <= '0;
      r_err <= 1'b0;
    end else begin
      r_nxt <= w_nxt_d;
      r_old <= w_old_d;
      r_err <= w_err_d;
    end
  end

  assign alloc_gnt   = w_gnt;
  assign alloc_itag  = r_nxt;
  assign oldest_itag = r_old;
  assign count       = w_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign err         = r_err;

endmodule
